// File: rtl/ps2_key_writer.sv
// ps2_key_writer
// Receives PS/2 keyboard frames, decodes make/break/extended codes and stores
// make codes as bytes into a ring buffer in the keyboard data memory. After
// every stored code the updated head pointer is written as a word at HEAD_ADDR
// so CPU software can poll for new keys.
//
// Ports:
//   clk        system clock, same as the memory write port clock
//   clrn       asynchronous active-low reset
//   ps2_clk    raw PS/2 clock from the pad (asynchronous)
//   ps2_data   raw PS/2 data from the pad (asynchronous)
//   waddr      memory byte write address
//   datain     memory write data
//   memop      store width: 0 = byte, 2 = word
//   we         memory write enable, one-cycle pulses
//   key_valid  one-cycle pulse when a make code is accepted
//   last_code  most recently accepted make code
//   frame_err  sticky error flag (parity/start/stop, timeout, dropped byte)
//   clr_err    synchronous clear of frame_err (a simultaneous new error wins)
module ps2_key_writer #(
    parameter int         BUF_DEPTH = 64,
    parameter logic [7:0] HEAD_ADDR = 8'hFC,
    parameter int         TIMEOUT   = 100000
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [7:0]  waddr,
    output logic [31:0] datain,
    output logic [2:0]  memop,
    output logic        we,
    output logic        key_valid,
    output logic [7:0]  last_code,
    output logic        frame_err,
    input  logic        clr_err
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_PFX  = 2'd1,
        WR_CODE = 2'd2,
        WR_HEAD = 2'd3
    } wr_state_t;

    // Odd parity over data plus parity bit: a correct frame has an odd count of ones.
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

    logic [2:0]    ps2c_sync_r;
    logic [2:0]    ps2d_sync_r;
    logic [3:0]    bit_cnt_r;
    logic [9:0]    shift_r;
    logic [TW-1:0] tmo_cnt_r;
    logic          break_r;
    logic          ext_r;
    logic [7:0]    code_r;
    logic [PW-1:0] wptr_r;
    logic          key_valid_r;
    logic [7:0]    last_code_r;
    logic          frame_err_r;
    logic          we_r;
    logic [7:0]    waddr_r;
    logic [31:0]   datain_r;
    logic [2:0]    memop_r;
    wr_state_t     state_r;
    wr_state_t     state_next_s;

    logic          fall_s;
    logic          rx_bit_s;
    logic          frame_done_s;
    logic          frame_good_s;
    logic [7:0]    rx_byte_s;
    logic          is_e0_s;
    logic          is_f0_s;
    logic          release_s;
    logic          make_s;
    logic          accept_s;
    logic          drop_s;
    logic          tmo_hit_s;
    logic          err_set_s;
    logic [7:0]    wptr_ext_s;
    logic          we_s;
    logic [7:0]    waddr_s;
    logic [31:0]   datain_s;
    logic [2:0]    memop_s;

    assign waddr     = waddr_r;
    assign datain    = datain_r;
    assign memop     = memop_r;
    assign we        = we_r;
    assign key_valid = key_valid_r;
    assign last_code = last_code_r;
    assign frame_err = frame_err_r;

    // Edge detect and frame classification derived from the synchronized pad lines.
    always_comb begin
        fall_s       = ps2c_sync_r[2] & ~ps2c_sync_r[1];
        rx_bit_s     = ps2d_sync_r[2];
        frame_done_s = fall_s && (bit_cnt_r == 4'd10);
        // After ten right shifts: [0]=start, [8:1]=data, [9]=parity; stop is the live bit.
        rx_byte_s    = shift_r[8:1];
        if (frame_done_s && (shift_r[0] == 1'b0) && rx_bit_s &&
            odd_parity_ok(shift_r[8:1], shift_r[9])) begin
            frame_good_s = 1'b1;
        end else begin
            frame_good_s = 1'b0;
        end
        is_e0_s    = (rx_byte_s == 8'hE0);
        is_f0_s    = (rx_byte_s == 8'hF0);
        release_s  = frame_good_s && !is_e0_s && !is_f0_s && break_r;
        make_s     = frame_good_s && !is_e0_s && !is_f0_s && !break_r;
        accept_s   = make_s && (state_r == IDLE);
        drop_s     = make_s && (state_r != IDLE);
        // The falling edge restarts the timeout, so a hit only counts without one.
        tmo_hit_s  = !fall_s && (bit_cnt_r != 4'd0) && (tmo_cnt_r == TMO_LAST);
        err_set_s  = (frame_done_s && !frame_good_s) || tmo_hit_s || drop_s;
        wptr_ext_s = {{(8 - PW){1'b0}}, wptr_r};
    end

    // Three-flop synchronizers for the asynchronous PS/2 pad lines (idle high).
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ps2c_sync_r <= 3'b111;
            ps2d_sync_r <= 3'b111;
        end else begin
            ps2c_sync_r <= {ps2c_sync_r[1:0], ps2_clk};
            ps2d_sync_r <= {ps2d_sync_r[1:0], ps2_data};
        end
    end

    // Bit counter, shift register and partial-frame timeout.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            bit_cnt_r <= 4'd0;
            shift_r   <= 10'd0;
            tmo_cnt_r <= '0;
        end else if (fall_s) begin
            tmo_cnt_r <= '0;
            shift_r   <= {rx_bit_s, shift_r[9:1]};
            if (bit_cnt_r == 4'd10) begin
                bit_cnt_r <= 4'd0;
            end else begin
                bit_cnt_r <= bit_cnt_r + 4'd1;
            end
        end else if (tmo_hit_s) begin
            bit_cnt_r <= 4'd0;
            tmo_cnt_r <= '0;
        end else if (bit_cnt_r != 4'd0) begin
            tmo_cnt_r <= tmo_cnt_r + {{(TW - 1){1'b0}}, 1'b1};
        end else begin
            tmo_cnt_r <= '0;
        end
    end

    // Decode flags, accepted code latch and key_valid/last_code reporting.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            break_r     <= 1'b0;
            ext_r       <= 1'b0;
            code_r      <= 8'd0;
            key_valid_r <= 1'b0;
            last_code_r <= 8'd0;
        end else begin
            key_valid_r <= make_s;
            if (make_s) begin
                last_code_r <= rx_byte_s;
            end else begin
                last_code_r <= last_code_r;
            end
            // Only an accepted code is latched so a dropped one cannot corrupt a write in flight.
            if (accept_s) begin
                code_r <= rx_byte_s;
            end else begin
                code_r <= code_r;
            end
            if (frame_good_s && is_f0_s) begin
                break_r <= 1'b1;
            end else if (release_s) begin
                break_r <= 1'b0;
            end else begin
                break_r <= break_r;
            end
            if (frame_good_s && is_e0_s) begin
                ext_r <= 1'b1;
            end else if (release_s || (state_r == WR_CODE)) begin
                ext_r <= 1'b0;
            end else begin
                ext_r <= ext_r;
            end
        end
    end

    // Sticky error flag; a new error beats a simultaneous clear.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            frame_err_r <= 1'b0;
        end else if (err_set_s) begin
            frame_err_r <= 1'b1;
        end else if (clr_err) begin
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= frame_err_r;
        end
    end

    // Write FSM state register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Write FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = ext_r ? WR_PFX : WR_CODE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WR_PFX:  state_next_s = WR_CODE;
            WR_CODE: state_next_s = WR_HEAD;
            WR_HEAD: state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Write FSM output decode; the port values hold while idle.
    always_comb begin
        we_s     = 1'b0;
        waddr_s  = waddr_r;
        datain_s = datain_r;
        memop_s  = memop_r;
        case (state_r)
            WR_PFX: begin
                we_s     = 1'b1;
                waddr_s  = wptr_ext_s;
                datain_s = 32'h0000_00E0;
                memop_s  = 3'd0;
            end
            WR_CODE: begin
                we_s     = 1'b1;
                waddr_s  = wptr_ext_s;
                datain_s = {24'h00_0000, code_r};
                memop_s  = 3'd0;
            end
            WR_HEAD: begin
                // wptr has already advanced past the code byte on entry here.
                we_s     = 1'b1;
                waddr_s  = HEAD_ADDR;
                datain_s = {24'h00_0000, wptr_ext_s};
                memop_s  = 3'd2;
            end
            default: begin
                we_s     = 1'b0;
                waddr_s  = waddr_r;
                datain_s = datain_r;
                memop_s  = memop_r;
            end
        endcase
    end

    // Registered memory write port.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            we_r     <= 1'b0;
            waddr_r  <= 8'd0;
            datain_r <= 32'd0;
            memop_r  <= 3'd0;
        end else begin
            we_r     <= we_s;
            waddr_r  <= waddr_s;
            datain_r <= datain_s;
            memop_r  <= memop_s;
        end
    end

    // Ring buffer write pointer; wraps naturally because BUF_DEPTH is a power of two.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wptr_r <= '0;
        end else if ((state_r == WR_PFX) || (state_r == WR_CODE)) begin
            wptr_r <= wptr_r + {{(PW - 1){1'b0}}, 1'b1};
        end else begin
            wptr_r <= wptr_r;
        end
    end

endmodule

// File: tb/tb_ps2_key_writer.sv
module tb_ps2_key_writer;

    localparam int         DEPTH = 64;
    localparam logic [7:0] HEAD  = 8'hFC;
    localparam int         TMO   = 100;
    localparam int         HP    = 6;
    localparam int         GAP   = 20;

    logic        clk;
    logic        clrn;
    logic        ps2_clk;
    logic        ps2_data;
    logic [7:0]  waddr;
    logic [31:0] datain;
    logic [2:0]  memop;
    logic        we;
    logic        key_valid;
    logic [7:0]  last_code;
    logic        frame_err;
    logic        clr_err;

    ps2_key_writer #(.BUF_DEPTH(DEPTH), .HEAD_ADDR(HEAD), .TIMEOUT(TMO)) dut (
        .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .waddr(waddr), .datain(datain), .memop(memop), .we(we),
        .key_valid(key_valid), .last_code(last_code), .frame_err(frame_err),
        .clr_err(clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state: what software would see after each decoded byte.
    int           m_wptr;
    logic         m_ext;
    logic         m_brk;
    logic         m_err;
    logic [42:0]  exp_wq[$];
    logic [7:0]   exp_codes[$];
    int           exp_run[$];
    logic [42:0]  obs[$];
    int           run;
    int           last_run;

    function automatic logic [42:0] mk(input int a, input int op, input int d);
        return {a[7:0], op[2:0], d[31:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic model_reset();
        m_wptr = 0; m_ext = 1'b0; m_brk = 1'b0; m_err = 1'b0;
        exp_wq.delete(); exp_codes.delete(); exp_run.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else if (m_brk) begin
            m_brk = 1'b0; m_ext = 1'b0;
        end else begin
            exp_codes.push_back(b);
            exp_run.push_back(m_ext ? 3 : 2);
            if (m_ext) begin
                exp_wq.push_back(mk(m_wptr, 0, 32'hE0));
                m_wptr = (m_wptr + 1) % DEPTH;
            end
            exp_wq.push_back(mk(m_wptr, 0, int'(b)));
            m_wptr = (m_wptr + 1) % DEPTH;
            exp_wq.push_back(mk(int'(HEAD), 2, m_wptr));
            m_ext = 1'b0;
        end
    endtask

    // Compare process: every write, key pulse and write burst length against the model.
    always @(negedge clk) begin
        if (!clrn) begin
            run = 0;
        end else begin
            if (we) begin
                obs.push_back({waddr, memop, datain});
                run++;
                if (exp_wq.size() == 0) chk("unexpected_write", {waddr, memop, datain}, 64'h0);
                else chk("write", {waddr, memop, datain}, exp_wq.pop_front());
            end else if (run > 0) begin
                last_run = run;
                if (exp_run.size() == 0) chk("unexpected_burst", 64'(run), 64'd0);
                else chk("burst_len", 64'(run), 64'(exp_run.pop_front()));
                run = 0;
            end
            if (key_valid) begin
                if (exp_codes.size() == 0) chk("unexpected_key", 64'(last_code), 64'h100);
                else chk("last_code", 64'(last_code), 64'(exp_codes.pop_front()));
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives nbits of a frame for b; nbits<11 leaves a partial frame behind.
    task automatic send_frame(input logic [7:0] b, input logic par_flip, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ par_flip, b, 1'b0};
        if (nbits == 11) begin
            if (par_flip) m_err = 1'b1;
            else model_byte(b);
        end
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            wait_cyc(HP);
            ps2_clk = 1'b0;
            wait_cyc(HP);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        wait_cyc(GAP);
        chk("frame_err_model", 64'(frame_err), 64'(m_err));
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 11);
    endtask

    task automatic clear_err();
        clr_err = 1'b1;
        wait_cyc(1);
        clr_err = 1'b0;
        m_err = 1'b0;
        wait_cyc(1);
        chk("frame_err_cleared", 64'(frame_err), 64'd0);
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        model_reset();
        wait_cyc(3);
        clrn = 1'b1;
        wait_cyc(2);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int seen;
        logic [7:0] code;
        clrn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; clr_err = 1'b0;
        run = 0; last_run = 0;
        model_reset();
        wait_cyc(3);
        chk("rst_we", 64'(we), 64'd0);
        chk("rst_key_valid", 64'(key_valid), 64'd0);
        chk("rst_frame_err", 64'(frame_err), 64'd0);
        chk("rst_last_code", 64'(last_code), 64'd0);
        chk("rst_waddr", 64'(waddr), 64'd0);
        chk("rst_datain", 64'(datain), 64'd0);
        chk("rst_memop", 64'(memop), 64'd0);
        clrn = 1'b1;
        wait_cyc(2);

        // Good 0x1C after reset: byte at 0, then head 1.
        base = obs.size();
        send(8'h1C);
        chk("t1_nwrites", 64'(obs.size() - base), 64'd2);
        chk("t1_byte", 64'(obs[base]), 64'(mk(8'h00, 0, 32'h1C)));
        chk("t1_head", 64'(obs[base+1]), 64'(mk(8'hFC, 2, 32'h01)));
        chk("t1_we_cycles", 64'(last_run), 64'd2);
        chk("t1_last_code", 64'(last_code), 64'h1C);

        // Bring wptr to 5, then extended up arrow.
        send(8'h1B); send(8'h23); send(8'h2B); send(8'h34);
        base = obs.size();
        send(8'hE0); send(8'h75);
        chk("t2_nwrites", 64'(obs.size() - base), 64'd3);
        chk("t2_pfx", 64'(obs[base]), 64'(mk(8'h05, 0, 32'hE0)));
        chk("t2_code", 64'(obs[base+1]), 64'(mk(8'h06, 0, 32'h75)));
        chk("t2_head", 64'(obs[base+2]), 64'(mk(8'hFC, 2, 32'h07)));
        chk("t2_we_cycles", 64'(last_run), 64'd3);
        base = obs.size();
        send(8'hF0); send(8'hE0); send(8'h75);
        chk("t2_release_nowrite", 64'(obs.size() - base), 64'd0);

        // Bad parity, then clear.
        base = obs.size();
        send_frame(8'h1C, 1'b1, 11);
        chk("t3_nowrite", 64'(obs.size() - base), 64'd0);
        chk("t3_err", 64'(frame_err), 64'd1);
        clear_err();

        // Partial frame timeout, then a good frame still works.
        send_frame(8'h1C, 1'b0, 4);
        wait_cyc(TMO + 20);
        m_err = 1'b1;
        chk("t4_timeout_err", 64'(frame_err), 64'd1);
        base = obs.size();
        send(8'h1C);
        chk("t4_nwrites", 64'(obs.size() - base), 64'd2);
        chk("t4_byte", 64'(obs[base]), 64'(mk(8'h07, 0, 32'h1C)));
        chk("t4_head", 64'(obs[base+1]), 64'(mk(8'hFC, 2, 32'h08)));
        clear_err();

        // 65 make codes wrap the ring buffer.
        do_reset();
        base = obs.size();
        for (int i = 0; i < 65; i++) send(8'($urandom_range(1, 223)));
        chk("t5_nwrites", 64'(obs.size() - base), 64'd130);
        chk("t5_addr64", 64'(obs[base+126][42:35]), 64'h3F);
        chk("t5_wrap_addr", 64'(obs[base+128][42:35]), 64'h00);
        chk("t5_wrap_head", 64'(obs[base+129]), 64'(mk(8'hFC, 2, 32'h01)));

        // Reset while the code byte is being written.
        seen = 0;
        fork
            send_frame(8'h4D, 1'b0, 11);
            begin
                for (int k = 0; k < 400 && seen == 0; k++) begin
                    @(negedge clk);
                    if (we && datain == 32'h4D) seen = 1;
                end
                if (seen == 0) chk("t6_code_write_timeout", 64'd0, 64'd1);
                @(posedge clk);
                #2;
                clrn = 1'b0;
                model_reset();
                #1;
                chk("t6_we_drop", 64'(we), 64'd0);
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("t6_we_hold", 64'(we), 64'd0);
                end
            end
        join
        wait_cyc(1);
        clrn = 1'b1;
        wait_cyc(2);
        base = obs.size();
        send(8'h1C);
        chk("t6_byte", 64'(obs[base]), 64'(mk(8'h00, 0, 32'h1C)));
        chk("t6_head", 64'(obs[base+1]), 64'(mk(8'hFC, 2, 32'h01)));

        // Randomized traffic against the model.
        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(0, 9);
            code = 8'($urandom_range(1, 223));
            if (r <= 4) send(code);
            else if (r <= 6) begin send(8'hE0); send(code); end
            else if (r == 7) begin send(8'hF0); send(code); end
            else if (r == 8) begin send(8'hE0); send(8'hF0); send(code); end
            else begin
                send_frame(code, 1'b1, 11);
                clear_err();
            end
        end

        wait_cyc(10);
        chk("end_writes_drained", 64'(exp_wq.size()), 64'd0);
        chk("end_keys_drained", 64'(exp_codes.size()), 64'd0);
        chk("end_bursts_drained", 64'(exp_run.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
